// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures memory-stage results and selects the write-back value.
// Latency 1 clock; stall holds the entry, flush inserts a bubble (flush wins over stall).
module mem_wb_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        validIn,
   input  logic        RegWrite,
   input  logic        MemtoReg,
   input  logic [4:0]  rd,
   input  logic [31:0] aluresult,
   input  logic [31:0] memData,
   output logic        wbRegWrite,
   output logic [4:0]  wbRd,
   output logic [31:0] wbData,
   output logic        wbValid,
   output logic        fwRegWrite,
   output logic [4:0]  fwRd,
   output logic [31:0] fwData,
   output logic [31:0] retireCount
);

   logic        vReg;
   logic        rwReg;
   logic        m2rReg;
   logic [4:0]  rdReg;
   logic [31:0] aluReg;
   logic [31:0] memReg;
   logic [31:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         vReg   <= 1'b0;
         rwReg  <= 1'b0;
         m2rReg <= 1'b0;
         rdReg  <= 5'd0;
         aluReg <= 32'd0;
         memReg <= 32'd0;
         cnt    <= 32'd0;
      end else if (flush) begin
         // Bubble: only the valid and write-enable bits matter; data is left as is.
         vReg  <= 1'b0;
         rwReg <= 1'b0;
      end else if (!stall) begin
         vReg   <= validIn;
         rwReg  <= RegWrite;
         m2rReg <= MemtoReg;
         rdReg  <= rd;
         aluReg <= aluresult;
         memReg <= memData;
         cnt    <= cnt + {31'd0, validIn};
      end
   end

   // r0 writes and bubbles are masked here so the forwarding unit never matches them either.
   assign wbRegWrite  = vReg & rwReg & (rdReg != 5'd0);
   assign wbRd        = rdReg;
   assign wbData      = m2rReg ? memReg : aluReg;
   assign wbValid     = vReg;
   assign fwRegWrite  = wbRegWrite;
   assign fwRd        = wbRd;
   assign fwData      = wbData;
   assign retireCount = cnt;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register and write-back stage that sits directly after the memory stage. It captures the memory stage's control and data outputs on each clock edge and selects the write-back value (load data or ALU result). It drives the register-file write port and the forwarding unit's WB-stage inputs. It supports stall (hold), flush (bubble insertion) and a retired-instruction counter for bench and debug visibility.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register index).
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold current contents; the upstream stage keeps its values
- flush  in  1  load a bubble (valid=0) instead of upstream values
- validIn  in  1  upstream slot holds a real instruction
- RegWrite  in  1  upstream register-write enable
- MemtoReg  in  1  1 = write back load data, 0 = write back ALU result
- rd  in  5  upstream destination register
- aluresult  in  32  ALU result passed through the memory stage
- memData  in  32  data memory read data for the same instruction
- wbRegWrite  out  1  register-file write enable
- wbRd  out  5  register-file write index
- wbData  out  32  register-file write data
- wbValid  out  1  WB slot holds a real instruction
- fwRegWrite  out  1  to forwarding unit; equals wbRegWrite
- fwRd  out  5  to forwarding unit; equals wbRd
- fwData  out  32  to forwarding unit; equals wbData
- retireCount  out  32  count of valid instructions captured into WB

## Operation
- Internal registers: vReg, rwReg, m2rReg, rdReg[4:0], aluReg[31:0], memReg[31:0], cnt[31:0].
- Per-edge priority is reset > flush > stall > normal load.
  - reset: all registers are cleared to 0.
  - flush: vReg=0 and rwReg=0. The data registers may take any value, but wbRegWrite must be 0. cnt is unchanged.
  - stall (no flush): all registers hold, including cnt.
  - normal: vReg=validIn, rwReg=RegWrite, m2rReg=MemtoReg, rdReg=rd, aluReg=aluresult, memReg=memData. cnt increments by 1 when validIn=1.
- Both memData and aluresult are captured at the same edge. The memory stage's read data is combinational for the current address, so no extra cycle is taken.
- Combinational outputs from the registers:
  - wbData = m2rReg ? memReg : aluReg
  - wbRegWrite = vReg & rwReg & (rdReg != 0); writes to r0 are always suppressed
  - wbRd = rdReg; wbValid = vReg; retireCount = cnt
  - fw* outputs mirror wb* exactly, so the forwarding unit never matches r0 or a bubble.
- No state machine beyond the valid bit. The stage is a single-entry buffer with hold and bubble controls.
- cnt wraps modulo 2^32: 0xFFFFFFFF + 1 = 0.

## Timing
- Latency: 1 clock. Inputs present before edge N appear on the outputs after edge N and remain until the next non-stalled edge.
- Outputs change only on clk rising edges; there is no combinational path from any input to any output.
- Reset values: wbRegWrite=0, wbRd=0, wbData=0, wbValid=0, fwRegWrite=0, fwRd=0, fwData=0, retireCount=0.
- Reset asserted mid-stream clears the stage at that edge and discards the in-flight entry. Deasserting reset allows capture on the next edge.
- Flush and stall both high: flush wins, and a bubble is loaded.
- Stall held for K cycles: the outputs, including wbRegWrite, stay constant for K cycles. The register file sees a repeated identical write, which is harmless.
- validIn=0 with RegWrite=1: wbRegWrite=0 and the counter does not increment.

## Test plan
- Reset: hold reset for 2 cycles with random inputs -> every output is 0 and retireCount=0.
- ALU write-back: validIn=1, RegWrite=1, MemtoReg=0, rd=6, aluresult=2, memData=99 -> after 1 edge, wbRegWrite=1, wbRd=6, wbData=2, fwData=2, retireCount=1.
- Load write-back: validIn=1, RegWrite=1, MemtoReg=1, rd=6, aluresult=2, memData=4 -> wbData=4. Follow with rd=0, aluresult=7, MemtoReg=0 -> wbRegWrite=0, fwRegWrite=0, wbData=7, retireCount=2.
- Stall: load rd=3, aluresult=0x55 (validIn=1, RegWrite=1, MemtoReg=0), then stall=1 for 3 cycles while the inputs change to rd=9, aluresult=0xAA -> outputs stay at rd=3, data=0x55, and retireCount does not change. Releasing stall -> rd=9, data=0xAA appear after 1 edge.
- Flush priority: stall=1, flush=1, validIn=1, RegWrite=1, rd=5 -> after the edge, wbValid=0, wbRegWrite=0, fwRegWrite=0, retireCount unchanged. Reset pulsed mid-stream -> all outputs are 0 after that edge.
- Counter wrap: force or preload the count to 0xFFFFFFFF (the bench drives 2^32-1 valid loads or uses a hierarchical deposit), then perform one valid load -> retireCount=0.
